// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID pipeline register: owns the PC, drives the
// instruction memory read port, inserts bubbles on redirect/wait, and stops on HALT.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_WORD = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic [15:0] imem_rdata,
    input  logic        imem_ready,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic [15:0] pc_inc_out,
    output logic        valid_out,
    output logic        halted
);

    localparam int unsigned XLEN = 16;
    localparam logic [0:0]  ST_RUN  = 1'b0;
    localparam logic [0:0]  ST_HALT = 1'b1;
    localparam logic [4:0]  OP_HALT = 5'b00000;

    logic [0:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic [XLEN-1:0] pc_inc_q, pc_inc_d;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] pc_plus2;

    assign pc_plus2 = pc_q + XLEN'(2);

    // Next-state: redirect beats stall beats memory response; bubbles keep pc fields.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        pc_inc_d = pc_inc_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        if (redirect) begin
            pc_d     = {redirect_pc[XLEN-1:1], 1'b0};
            instr_d  = NOP_WORD;
            valid_d  = 1'b0;
            state_d  = ST_RUN;
            halted_d = 1'b0;
        end else if (!stall) begin
            case (state_q)
                ST_RUN: begin
                    if (imem_ready) begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_q;
                        pc_inc_d = pc_plus2;
                        valid_d  = 1'b1;
                        if (imem_rdata[15:11] == OP_HALT) begin
                            state_d  = ST_HALT;
                            halted_d = 1'b1;
                        end else begin
                            pc_d = pc_plus2;
                        end
                    end else begin
                        instr_d = NOP_WORD;
                        valid_d = 1'b0;
                    end
                end
                default: begin
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_WORD;
            pc_out_q <= '0;
            pc_inc_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            pc_inc_q <= pc_inc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    // Read request keeps asserting through stalls so the same address is re-read.
    assign imem_rd    = (state_q == ST_RUN) && !rst;
    assign imem_addr  = pc_q;
    assign instr_out  = instr_q;
    assign pc_out     = pc_out_q;
    assign pc_inc_out = pc_inc_q;
    assign valid_out  = valid_q;
    assign halted     = halted_q;

endmodule
